// File: rtl/pipeline_exe_mc_if.sv
// EXE stage bus: ID-side request, MEM-side result and the IF redirect.
interface pipeline_exe_mc_if #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [3:0]        op_i;
    logic [XLEN-1:0]   a_i;
    logic [XLEN-1:0]   b_i;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   pc_plus4_i;
    logic [XLEN-1:0]   pred_pc_i;
    logic              taken_i;
    logic              is_branch_i;
    logic [2:0]        br_f3_i;
    logic              jalr_i;
    logic [RIDX_W-1:0] rd_i;
    logic              wen_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   result_o;
    logic [RIDX_W-1:0] rd_o;
    logic              wen_o;
    logic              redirect_o;
    logic [XLEN-1:0]   redirect_pc_o;

    // ID/MEM/IF side of the stage
    modport master (
        output in_valid_i, op_i, a_i, b_i, imm_i, pc_plus4_i, pred_pc_i, taken_i,
               is_branch_i, br_f3_i, jalr_i, rd_i, wen_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, rd_o, wen_o, redirect_o, redirect_pc_o
    );

    // The EXE stage itself
    modport slave (
        input  in_valid_i, op_i, a_i, b_i, imm_i, pc_plus4_i, pred_pc_i, taken_i,
               is_branch_i, br_f3_i, jalr_i, rd_i, wen_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, rd_o, wen_o, redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/pipeline_exe_mc.sv
// EXE stage: single-cycle ALU, iterative radix-2 divider, branch/jalr resolution.
//
//  state | meaning
//  IDLE  | ready for a new instruction (subject to output back-pressure)
//  BUSY  | divider iterating, ID stalled
//  DONE  | quotient/remainder ready, waiting for the output register to be free
module pipeline_exe_mc #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5,
    parameter int CNT_W  = 6
) (
    input logic              clk,
    input logic              resetn,
    pipeline_exe_mc_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REM  = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;
    logic [RIDX_W-1:0] prd_q, prd_d;
    logic              pwen_q, pwen_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [RIDX_W-1:0] rd_q, rd_d;
    logic              wen_q, wen_d;
    logic              redirect_q, redirect_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

    logic              out_free, in_ready, accept;
    logic [SH_W-1:0]   shamt;
    logic              is_div, div_signed, div_rem, div_zero, div_ovf, div_special;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b, alu_res, fast_res, div_final;
    logic              br_actual, mispredict;
    logic [XLEN-1:0]   target;
    logic [2*XLEN-1:0] step_first, step_busy;

    // One restoring-division step; {remainder, quotient/dividend shift register}.
    // The invariant rem < dsr means the borrow bit alone tells whether to subtract.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dsr);
        logic [XLEN:0] shifted;
        logic [XLEN:0] diff;
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dsr};
        if (!diff[XLEN]) return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
        return {shifted[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    endfunction

    assign out_free   = ~out_valid_q | bus.out_ready_i;
    assign in_ready   = resetn & (state_q == IDLE) & out_free;
    assign accept     = bus.in_valid_i & in_ready;
    assign shamt      = bus.b_i[SH_W-1:0];
    // First iteration happens on the accept edge so the result lands XLEN+1 cycles later.
    assign step_first = div_step('0, mag_a, mag_b);
    assign step_busy  = div_step(rem_q, quo_q, dsr_q);

    // Single-cycle integer ALU
    always_comb begin
        alu_res = bus.a_i + bus.b_i;
        case (bus.op_i)
            OP_SUB:  alu_res = bus.a_i - bus.b_i;
            OP_AND:  alu_res = bus.a_i & bus.b_i;
            OP_OR:   alu_res = bus.a_i | bus.b_i;
            OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
            OP_SLL:  alu_res = bus.a_i << shamt;
            OP_SRL:  alu_res = bus.a_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.a_i) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a_i) < $signed(bus.b_i)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.a_i < bus.b_i};
            default: ;
        endcase
    end

    // Divide decode, operand magnitudes and the one-cycle special cases
    always_comb begin
        is_div      = (bus.op_i >= OP_DIV) && (bus.op_i <= OP_REMU);
        div_signed  = (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
        div_rem     = (bus.op_i == OP_REM) || (bus.op_i == OP_REMU);
        neg_a       = div_signed & bus.a_i[XLEN-1];
        neg_b       = div_signed & bus.b_i[XLEN-1];
        mag_a       = neg_a ? -bus.a_i : bus.a_i;
        mag_b       = neg_b ? -bus.b_i : bus.b_i;
        div_zero    = (bus.b_i == '0);
        div_ovf     = div_signed & (bus.a_i == SMIN) & (bus.b_i == '1);
        div_special = div_zero | div_ovf;
        if (is_div) begin
            if (div_zero) fast_res = div_rem ? bus.a_i : '1;
            else          fast_res = div_rem ? '0 : bus.a_i;
        end else if (bus.jalr_i) begin
            fast_res = bus.pc_plus4_i;
        end else begin
            fast_res = alu_res;
        end
        div_final = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                             : (neg_quo_q ? -quo_q : quo_q);
    end

    // Branch / jalr outcome and corrected target
    always_comb begin
        case (bus.br_f3_i)
            3'b000:  br_actual = (bus.a_i == bus.b_i);
            3'b001:  br_actual = (bus.a_i != bus.b_i);
            3'b100:  br_actual = ($signed(bus.a_i) <  $signed(bus.b_i));
            3'b101:  br_actual = ($signed(bus.a_i) >= $signed(bus.b_i));
            3'b110:  br_actual = (bus.a_i <  bus.b_i);
            3'b111:  br_actual = (bus.a_i >= bus.b_i);
            default: br_actual = 1'b0;
        endcase
        if (bus.jalr_i) begin
            mispredict = ~bus.taken_i;
            target     = (bus.a_i + bus.imm_i) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            mispredict = bus.is_branch_i & (br_actual != bus.taken_i);
            target     = br_actual ? bus.pred_pc_i : bus.pc_plus4_i;
        end
    end

    // Divider FSM next state, output register and redirect pulse; flush overrides all
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dsr_d         = dsr_q;
        cnt_d         = cnt_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        is_rem_d      = is_rem_q;
        prd_d         = prd_q;
        pwen_d        = pwen_q;
        out_valid_d   = out_valid_q & ~bus.out_ready_i;
        result_d      = result_q;
        rd_d          = rd_q;
        wen_d         = wen_q;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_div && !div_special) begin
                        state_d        = BUSY;
                        {rem_d, quo_d} = step_first;
                        dsr_d          = mag_b;
                        cnt_d          = CNT_W'(XLEN - 1);
                        neg_quo_d      = neg_a ^ neg_b;
                        neg_rem_d      = neg_a;
                        is_rem_d       = div_rem;
                        prd_d          = bus.rd_i;
                        pwen_d         = bus.wen_i;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = fast_res;
                        rd_d        = bus.rd_i;
                        wen_d       = bus.wen_i;
                    end
                    if (mispredict) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = target;
                    end
                end
            end
            BUSY: begin
                {rem_d, quo_d} = step_busy;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    result_d    = div_final;
                    rd_d        = prd_q;
                    wen_d       = pwen_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) begin
            state_d       = IDLE;
            out_valid_d   = 1'b0;
            redirect_d    = 1'b0;
            redirect_pc_d = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            dsr_q         <= '0;
            cnt_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            is_rem_q      <= 1'b0;
            prd_q         <= '0;
            pwen_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            rd_q          <= '0;
            wen_q         <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dsr_q         <= dsr_d;
            cnt_q         <= cnt_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            is_rem_q      <= is_rem_d;
            prd_q         <= prd_d;
            pwen_q        <= pwen_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            rd_q          <= rd_d;
            wen_q         <= wen_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.result_o      = result_q;
    assign bus.rd_o          = rd_q;
    assign bus.wen_o         = wen_q;
    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;
endmodule

// File: tb/tb_pipeline_exe_mc.sv
// Self-checking bench for pipeline_exe_mc with a behavioural reference model.
module tb_pipeline_exe_mc;
    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_exe_mc_if #(.XLEN(XLEN), .RIDX_W(RIDX_W)) bus ();
    pipeline_exe_mc #(.XLEN(XLEN), .RIDX_W(RIDX_W), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc4, pred;
        logic        taken, isbr, jalr, wen;
        logic [2:0]  f3;
        logic [4:0]  rd;
    } instr_t;

    // ---------------- reference model ----------------
    function automatic bit is_div_op(logic [3:0] op);
        return (op >= 4'd10) && (op <= 4'd13);
    endfunction

    function automatic logic [31:0] ref_result(instr_t t);
        int unsigned sh = t.b % 32;
        bit ovf = (t.a == 32'h8000_0000) && (t.b == 32'hFFFF_FFFF);
        if (t.jalr && !is_div_op(t.op)) return t.pc4;
        case (t.op)
            4'd1:  return t.a - t.b;
            4'd2:  return t.a & t.b;
            4'd3:  return t.a | t.b;
            4'd4:  return t.a ^ t.b;
            4'd5:  return t.a << sh;
            4'd6:  return t.a >> sh;
            4'd7:  return 32'($signed(t.a) >>> sh);
            4'd8:  return ($signed(t.a) < $signed(t.b)) ? 32'd1 : 32'd0;
            4'd9:  return (t.a < t.b) ? 32'd1 : 32'd0;
            4'd10: return (t.b == 0) ? 32'hFFFF_FFFF : ovf ? t.a : 32'($signed(t.a) / $signed(t.b));
            4'd11: return (t.b == 0) ? 32'hFFFF_FFFF : t.a / t.b;
            4'd12: return (t.b == 0) ? t.a : ovf ? 32'd0 : 32'($signed(t.a) % $signed(t.b));
            4'd13: return (t.b == 0) ? t.a : t.a % t.b;
            default: return t.a + t.b;
        endcase
    endfunction

    function automatic int ref_latency(instr_t t);
        bit sgn = (t.op == 4'd10) || (t.op == 4'd12);
        bit ovf = sgn && (t.a == 32'h8000_0000) && (t.b == 32'hFFFF_FFFF);
        if (is_div_op(t.op) && (t.b != 0) && !ovf) return XLEN + 1;
        return 1;
    endfunction

    function automatic void ref_redirect(instr_t t, output logic r, output logic [31:0] pc);
        bit act;
        case (t.f3)
            3'b000:  act = (t.a == t.b);
            3'b001:  act = (t.a != t.b);
            3'b100:  act = ($signed(t.a) <  $signed(t.b));
            3'b101:  act = ($signed(t.a) >= $signed(t.b));
            3'b110:  act = (t.a <  t.b);
            3'b111:  act = (t.a >= t.b);
            default: act = 1'b0;
        endcase
        r  = 1'b0;
        pc = 32'd0;
        if (t.jalr) begin
            if (!t.taken) begin r = 1'b1; pc = (t.a + t.imm) & 32'hFFFF_FFFE; end
        end else if (t.isbr && (act != t.taken)) begin
            r  = 1'b1;
            pc = act ? t.pred : t.pc4;
        end
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 9));
            3:       return 32'd0;
            default: return $urandom();
        endcase
    endfunction

    function automatic instr_t rand_instr(bit allow_div);
        instr_t t;
        int op = allow_div ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 11));
        if (!allow_div && op >= 10) op = op + 4;
        t.op    = 4'(op);
        t.a     = rand_operand();
        t.b     = rand_operand();
        t.imm   = $urandom();
        t.pc4   = $urandom() & 32'hFFFF_FFFC;
        t.pred  = $urandom() & 32'hFFFF_FFFC;
        t.taken = 1'($urandom_range(0, 1));
        t.jalr  = !is_div_op(t.op) && ($urandom_range(0, 5) == 0);
        t.isbr  = !t.jalr && ($urandom_range(0, 2) == 0);
        t.f3    = 3'($urandom_range(0, 7));
        t.rd    = 5'($urandom_range(0, 31));
        t.wen   = 1'($urandom_range(0, 1));
        return t;
    endfunction

    task automatic present(input instr_t t, input logic flush);
        bus.in_valid_i  = 1'b1;
        bus.op_i        = t.op;
        bus.a_i         = t.a;
        bus.b_i         = t.b;
        bus.imm_i       = t.imm;
        bus.pc_plus4_i  = t.pc4;
        bus.pred_pc_i   = t.pred;
        bus.taken_i     = t.taken;
        bus.is_branch_i = t.isbr;
        bus.br_f3_i     = t.f3;
        bus.jalr_i      = t.jalr;
        bus.rd_i        = t.rd;
        bus.wen_i       = t.wen;
        bus.flush_i     = flush;
    endtask

    task automatic idle_inputs();
        bus.in_valid_i  = 1'b0;
        bus.flush_i     = 1'b0;
        bus.is_branch_i = 1'b0;
        bus.jalr_i      = 1'b0;
    endtask

    // Present one instruction for a single cycle; returns in_ready seen before the edge.
    task automatic issue(input instr_t t, input logic flush, output logic rdy);
        @(negedge clk);
        present(t, flush);
        #1 rdy = bus.in_ready_o;
        @(posedge clk);
        #1 idle_inputs();
    endtask

    // Cycles after the accept edge until out_valid_o rises (0 = timed out).
    task automatic wait_out(output int lat, output bit stayed_low);
        lat        = 0;
        stayed_low = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.out_valid_o) begin lat = k; break; end
            if (bus.in_ready_o) stayed_low = 1'b0;
        end
    endtask

    function automatic instr_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        instr_t t;
        t = rand_instr(0);
        t.op = op; t.a = a; t.b = b; t.jalr = 1'b0; t.isbr = 1'b0;
        return t;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        bus.out_ready_i = 1'b1;
        bus.op_i = '0; bus.a_i = '0; bus.b_i = '0; bus.imm_i = '0;
        bus.pc_plus4_i = '0; bus.pred_pc_i = '0; bus.taken_i = 1'b0;
        bus.br_f3_i = '0; bus.rd_i = '0; bus.wen_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid_o, bus.wen_o, bus.redirect_o, bus.in_ready_o} !== 4'b0000 ||
            bus.result_o !== 32'd0 || bus.rd_o !== 5'd0 || bus.redirect_pc_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b wen=%b redir=%b rdy=%b res=%h rd=%h rpc=%h, want all 0",
                     bus.out_valid_o, bus.wen_o, bus.redirect_o, bus.in_ready_o,
                     bus.result_o, bus.rd_o, bus.redirect_pc_o);
        end
        resetn = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got %b want 1", bus.in_ready_o);
        end
    endtask

    task automatic test_alu();
        instr_t t;
        logic [31:0] exp;
        logic rdy;
        for (int i = 0; i < 42; i++) begin
            t = rand_instr(0);
            if (i == 0) t = mk(4'd0, 32'hFFFF_FFFF, 32'd1);
            if (i == 1) t = mk(4'd7, 32'h8000_0000, 32'd35);
            exp = (i == 0) ? 32'd0 : (i == 1) ? 32'hF000_0000 : ref_result(t);
            issue(t, 1'b0, rdy);
            @(negedge clk);
            n_checks++;
            if (rdy !== 1'b1 || bus.out_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL alu_timing[%0d] ready=%b valid=%b want 1/1", i, rdy, bus.out_valid_o);
            end
            n_checks++;
            if (bus.result_o !== exp || bus.rd_o !== t.rd || bus.wen_o !== t.wen) begin
                n_fail++;
                $display("FAIL alu_result[%0d] op=%0d a=%h b=%h got %h/%0d/%b want %h/%0d/%b",
                         i, t.op, t.a, t.b, bus.result_o, bus.rd_o, bus.wen_o, exp, t.rd, t.wen);
            end
        end
    endtask

    task automatic test_div();
        instr_t t;
        logic [31:0] exp;
        logic rdy;
        int lat, elat;
        bit low;
        for (int i = 0; i < 20; i++) begin
            t = rand_instr(1);
            t.op = 4'(10 + (i % 4));
            t.jalr = 1'b0;
            case (i)
                0: t = mk(4'd10, 32'hFFFF_FFF9, 32'd2);
                1: t = mk(4'd12, 32'hFFFF_FFF9, 32'd2);
                2: t = mk(4'd11, 32'd5, 32'd0);
                3: t = mk(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
                4: t = mk(4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
                default: ;
            endcase
            case (i)
                0: begin exp = 32'hFFFF_FFFD; elat = 33; end
                1: begin exp = 32'hFFFF_FFFF; elat = 33; end
                2: begin exp = 32'hFFFF_FFFF; elat = 1;  end
                3: begin exp = 32'h8000_0000; elat = 1;  end
                4: begin exp = 32'd0;         elat = 1;  end
                default: begin exp = ref_result(t); elat = ref_latency(t); end
            endcase
            issue(t, 1'b0, rdy);
            wait_out(lat, low);
            n_checks++;
            if (rdy !== 1'b1 || lat != elat) begin
                n_fail++; $display("FAIL div_latency[%0d] op=%0d ready=%b got %0d want %0d", i, t.op, rdy, lat, elat);
            end
            if (elat > 1) begin
                n_checks++;
                if (!low) begin n_fail++; $display("FAIL div_stall[%0d] in_ready rose during divide, want 0", i); end
            end
            n_checks++;
            if (bus.result_o !== exp || bus.rd_o !== t.rd || bus.wen_o !== t.wen) begin
                n_fail++;
                $display("FAIL div_result[%0d] op=%0d a=%h b=%h got %h/%0d/%b want %h/%0d/%b",
                         i, t.op, t.a, t.b, bus.result_o, bus.rd_o, bus.wen_o, exp, t.rd, t.wen);
            end
        end
    endtask

    task automatic test_branch();
        instr_t t;
        logic er;
        logic [31:0] epc;
        logic rdy;
        for (int i = 0; i < 40; i++) begin
            t = rand_instr(0);
            if (i < 20) begin t.jalr = 1'b0; t.isbr = 1'b1; end
            if (i == 0) begin
                t = mk(4'd0, 32'hFFFF_FFFF, 32'd0);
                t.isbr = 1'b1; t.f3 = 3'b100; t.taken = 1'b0; t.pred = 32'h100; t.pc4 = 32'h204;
            end
            if (i == 1) begin
                t = mk(4'd0, 32'h201, 32'd0);
                t.jalr = 1'b1; t.imm = 32'd2; t.taken = 1'b0;
            end
            if (i == 0)      begin er = 1'b1; epc = 32'h100; end
            else if (i == 1) begin er = 1'b1; epc = 32'h202; end
            else ref_redirect(t, er, epc);
            issue(t, 1'b0, rdy);
            @(negedge clk);
            n_checks++;
            if (bus.redirect_o !== er || bus.redirect_pc_o !== epc) begin
                n_fail++;
                $display("FAIL redirect[%0d] f3=%b jalr=%b taken=%b got %b/%h want %b/%h",
                         i, t.f3, t.jalr, t.taken, bus.redirect_o, bus.redirect_pc_o, er, epc);
            end
            @(negedge clk);
            n_checks++;
            if (bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'd0) begin
                n_fail++; $display("FAIL redirect_pulse[%0d] got %b/%h want 0/0", i, bus.redirect_o, bus.redirect_pc_o);
            end
        end
    endtask

    task automatic test_flush();
        instr_t t;
        logic rdy;
        int seen;
        issue(mk(4'd10, 32'd1000, 32'd7), 1'b0, rdy);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy got ready=%b valid=%b want 1/0", bus.in_ready_o, bus.out_valid_o);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid_o) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
        // flush on the accepting cycle of a mispredicted branch
        t = mk(4'd0, 32'hFFFF_FFFF, 32'd0);
        t.isbr = 1'b1; t.f3 = 3'b100; t.taken = 1'b0; t.pred = 32'h300;
        issue(t, 1'b1, rdy);
        @(negedge clk);
        n_checks++;
        if (rdy !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.redirect_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_accept got ready=%b valid=%b redir=%b want 1/0/0", rdy, bus.out_valid_o, bus.redirect_o);
        end
    endtask

    task automatic test_backpressure();
        logic rdy;
        int lat, bad;
        bit low;
        bus.out_ready_i = 1'b0;
        issue(mk(4'd10, 32'hFFFF_FFF9, 32'd2), 1'b0, rdy);
        wait_out(lat, low);
        n_checks++;
        if (rdy !== 1'b1 || lat != 33 || bus.result_o !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL bp_div got ready=%b lat=%0d res=%h want 1/33/fffffffd", rdy, lat, bus.result_o);
        end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.result_o !== 32'hFFFF_FFFD) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        bus.out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready_o); end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain got valid=%b want 0", bus.out_valid_o); end
    endtask

    task automatic test_back_to_back();
        instr_t q[$];
        instr_t cur, head;
        logic [31:0] exp;
        int sent = 0, got = 0;
        localparam int N = 30;
        cur = rand_instr(1);
        for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
            @(negedge clk);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            if (sent < N) present(cur, 1'b0);
            else idle_inputs();
            #1;
            if (bus.out_valid_o && bus.out_ready_i) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_spurious got result %h want no output", bus.result_o);
                end else begin
                    head = q.pop_front();
                    exp  = ref_result(head);
                    if (bus.result_o !== exp || bus.rd_o !== head.rd || bus.wen_o !== head.wen) begin
                        n_fail++;
                        $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h got %h/%0d want %h/%0d",
                                 got, head.op, head.a, head.b, bus.result_o, bus.rd_o, exp, head.rd);
                    end
                end
                got++;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                q.push_back(cur);
                sent++;
                cur = rand_instr(1);
            end
        end
        @(negedge clk);
        idle_inputs();
        bus.out_ready_i = 1'b1;
        n_checks++;
        if (got != N) begin n_fail++; $display("FAIL b2b_count got %0d results want %0d", got, N); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_div();
        test_branch();
        test_flush();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
